calc_result_rx: RTL and testbench

Downstream receiver for the binary calculator's serial result port. Samples the `SIZE`-bit `DataOut` chunk on each rising edge of `ClkTx` while `DoutValid` is high, and assembles `32/SIZE` consecutive chunks into a 32-bit result word. Completed words are queued in a small first-word-fall-through FIFO that the host pops.

---
 rtl/calc_result_rx.sv | 156 +++++++++++++++
 tb/tb_calc_result_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_result_rx.sv
// rtl/calc_result_rx.sv - serial result receiver: chunk assembler plus FWFT word FIFO
// Build option: CALC_RX_MSB_FIRST_EN selects most-significant-chunk-first assembly.
module calc_result_rx #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         DoutValid,
  input  logic [SIZE-1:0]              DataOut,
  input  logic                         ClkTx,
  input  logic                         RdEn,
  input  logic                         ClrErr,
  output logic [31:0]                  RdData,
  output logic                         Empty,
  output logic                         Full,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Overflow,
  output logic                         FrameErr
);

  localparam int CHUNKS = 32 / SIZE;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int NW     = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]     r_shift, w_shift_nxt;
  logic            r_clktx_q;
  logic            r_tx_armed;
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [NW-1:0]   r_count;
  logic            r_overflow, r_frame_err;

  logic            w_tx_edge;
  logic            w_push, w_abort, w_pop, w_wr, w_drop, w_full;
  logic [31:0]     w_chunk32, w_base, w_assembled;

  // Armed only after ClkTx has been seen low since reset, so a strobe held
  // high across reset release cannot look like a fresh edge.
  assign w_tx_edge = ClkTx & ~r_clktx_q & r_tx_armed;
  assign w_chunk32 = 32'(DataOut);
  assign w_base    = (r_state == S_IDLE) ? 32'd0 : r_shift;

`ifdef CALC_RX_MSB_FIRST_EN
  assign w_assembled = (w_base << SIZE) | w_chunk32;
`else
  assign w_assembled = (w_chunk32 << (32 - SIZE)) | (w_base >> SIZE);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_clktx_q  <= 1'b0;
      r_tx_armed <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_clktx_q  <= ClkTx;
      r_tx_armed <= r_tx_armed | ~ClkTx;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tx_edge && DoutValid) begin
          w_shift_nxt = w_assembled;
          if (CHUNKS == 1) begin
            w_push = 1'b1;
          end else begin
            w_cnt_nxt   = CW'(1);
            w_state_nxt = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (!DoutValid) begin
          w_abort     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_tx_edge) begin
          w_shift_nxt = w_assembled;
          if (r_cnt == CW'(CHUNKS - 1)) begin
            w_push      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A pop frees the slot this cycle, so a push into a full FIFO with a
  // simultaneous pop is still accepted.
  assign w_full = (r_count == NW'(DEPTH));
  assign w_pop  = RdEn & (r_count != '0);
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= w_assembled;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overflow  <= w_drop  | (r_overflow  & ~ClrErr);
      r_frame_err <= w_abort | (r_frame_err & ~ClrErr);
    end
  end

  assign RdData   = r_mem[r_rptr];
  assign Empty    = (r_count == '0);
  assign Full     = w_full;
  assign Count    = r_count;
  assign Overflow = r_overflow;
  assign FrameErr = r_frame_err;

endmodule

// File: tb/tb_calc_result_rx.sv
// tb/tb_calc_result_rx.sv - directed and randomized checks of calc_result_rx against a queue model
module tb_calc_result_rx;
  localparam int SIZE   = 4;
  localparam int DEPTH  = 4;
  localparam int CHUNKS = 32 / SIZE;

  logic            Clk = 1'b0;
  logic            Reset, DoutValid, ClkTx, RdEn, ClrErr;
  logic [SIZE-1:0] DataOut;
  logic [31:0]     RdData;
  logic            Empty, Full, Overflow, FrameErr;
  logic [$clog2(DEPTH+1)-1:0] Count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]     m_q[$];
  logic [SIZE-1:0] m_part[$];
  bit              m_prev_low;
  bit              m_ovf, m_ferr;

  calc_result_rx #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .DoutValid(DoutValid), .DataOut(DataOut),
    .ClkTx(ClkTx), .RdEn(RdEn), .ClrErr(ClrErr), .RdData(RdData),
    .Empty(Empty), .Full(Full), .Count(Count), .Overflow(Overflow), .FrameErr(FrameErr)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w = '0;
    for (int k = 0; k < CHUNKS; k++) begin
`ifdef CALC_RX_MSB_FIRST_EN
      w |= 32'(m_part[k]) << ((CHUNKS - 1 - k) * SIZE);
`else
      w |= 32'(m_part[k]) << (k * SIZE);
`endif
    end
    return w;
  endfunction

  task automatic model_step();
    bit          edge_seen = ClkTx && m_prev_low;
    bit          done = 0;
    bit          ovf_ev = 0, fe_ev = 0;
    logic [31:0] word = '0;
    if (m_part.size() > 0 && !DoutValid) begin
      m_part.delete();
      fe_ev = 1;
    end else if (edge_seen && DoutValid) begin
      m_part.push_back(DataOut);
      if (m_part.size() == CHUNKS) begin
        word = model_word();
        done = 1;
        m_part.delete();
      end
    end
    if (RdEn && m_q.size() > 0) void'(m_q.pop_front());
    if (done) begin
      if (m_q.size() < DEPTH) m_q.push_back(word);
      else ovf_ev = 1;
    end
    m_ovf      = ovf_ev || (m_ovf && !ClrErr);
    m_ferr     = fe_ev || (m_ferr && !ClrErr);
    m_prev_low = !ClkTx;
  endtask

  task automatic check_outputs();
    check_eq("count", 32'(Count), 32'(m_q.size()));
    check_eq("empty", 32'(Empty), 32'(m_q.size() == 0));
    check_eq("full", 32'(Full), 32'(m_q.size() == DEPTH));
    check_eq("overflow", 32'(Overflow), 32'(m_ovf));
    check_eq("frame_err", 32'(FrameErr), 32'(m_ferr));
    if (m_q.size() > 0) check_eq("rd_data", RdData, m_q[0]);
  endtask

  task automatic cyc(input logic tx, input logic dv, input logic [SIZE-1:0] d,
                     input logic rd, input logic clr);
    ClkTx = tx; DoutValid = dv; DataOut = d; RdEn = rd; ClrErr = clr;
    model_step();
    @(posedge Clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic tx_hold);
    Reset = 1'b1; ClkTx = tx_hold; DoutValid = 1'b0; DataOut = '0; RdEn = 1'b0; ClrErr = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    m_q.delete(); m_part.delete();
    m_prev_low = 0; m_ovf = 0; m_ferr = 0;
    check_eq("rst_empty", 32'(Empty), 32'd1);
    check_eq("rst_full", 32'(Full), 32'd0);
    check_eq("rst_count", 32'(Count), 32'd0);
    check_eq("rst_rd_data", RdData, 32'd0);
    check_eq("rst_overflow", 32'(Overflow), 32'd0);
    check_eq("rst_frame_err", 32'(FrameErr), 32'd0);
  endtask

  function automatic logic [SIZE-1:0] chunk_of(input logic [31:0] w, input int k);
`ifdef CALC_RX_MSB_FIRST_EN
    return w[(CHUNKS - 1 - k) * SIZE +: SIZE];
`else
    return w[k * SIZE +: SIZE];
`endif
  endfunction

  task automatic send_word(input logic [31:0] w, input logic rd_last);
    for (int k = 0; k < CHUNKS; k++) begin
      cyc(1'b1, 1'b1, chunk_of(w, k), (k == CHUNKS - 1) ? rd_last : 1'b0, 1'b0);
      cyc(1'b0, (k != CHUNKS - 1), chunk_of(w, k), 1'b0, 1'b0);
    end
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp);
    check_eq(tag, RdData, exp);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    do_reset(1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Single word, chunks 8..1 in LSB build (1..8 in MSB build).
    send_word(32'h12345678, 1'b0);
    check_eq("word_rd_data", RdData, 32'h12345678);
    check_eq("word_count", 32'(Count), 32'd1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("word_popped_empty", 32'(Empty), 32'd1);

    // Abort after 3 chunks, then a clean word, then clear.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 4'(k + 1), 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'(k + 1), 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("abort_frame_err", 32'(FrameErr), 32'd1);
    check_eq("abort_count", 32'(Count), 32'd0);
    send_word(32'hCAFEF00D, 1'b0);
    check_eq("abort_next_word", RdData, 32'hCAFEF00D);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_eq("clr_frame_err", 32'(FrameErr), 32'd0);

    // Overflow: five words into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) send_word(32'(i), 1'b0);
    check_eq("ovf_full", 32'(Full), 32'd1);
    check_eq("ovf_count", 32'(Count), 32'd4);
    check_eq("ovf_flag", 32'(Overflow), 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect("ovf_pop", 32'(i));
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Push and pop together while full.
    for (int i = 1; i <= 4; i++) send_word(32'(i), 1'b0);
    send_word(32'd5, 1'b1);
    check_eq("simul_count", 32'(Count), 32'd4);
    check_eq("simul_no_ovf", 32'(Overflow), 32'd0);
    for (int i = 2; i <= 5; i++) pop_expect("simul_pop", 32'(i));

    // Reset mid-word with a word queued, ClkTx held high across release.
    send_word(32'hA5A5_5A5A, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
    end
    do_reset(1'b1);
    cyc(1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
    check_eq("held_high_no_capture", 32'(Count), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    send_word(32'h0BAD_F00D, 1'b0);
    check_eq("post_reset_word", RdData, 32'h0BAD_F00D);
    check_eq("post_reset_no_err", 32'(FrameErr), 32'd0);

    // Randomized traffic with phases of slow and fast draining.
    for (int w = 0; w < 300; w++) begin
      int pop_div = ((w / 25) % 2 == 1) ? 3 : 40;
      int gap     = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        cyc(1'b0, 1'($urandom % 2), 4'($urandom), 1'($urandom % pop_div == 0), 1'($urandom % 16 == 0));
      for (int k = 0; k < CHUNKS; k++) begin
        logic [SIZE-1:0] d = 4'($urandom);
        cyc(1'b1, 1'($urandom % 50 != 0), d, 1'($urandom % pop_div == 0), 1'($urandom % 16 == 0));
        cyc(1'b0, 1'($urandom % 50 != 0), d, 1'($urandom % pop_div == 0), 1'($urandom % 16 == 0));
      end
      if (w == 150) do_reset($urandom % 2 == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
